decode_stage: RTL and testbench
===============================

# decode_stage

Registered decode stage directly upstream of the execute stage. It accepts one 32-bit instruction word per cycle from fetch, splits it into the execute control bundle (`num_to_rhs`, `num`, `sel_p0`, `sel_p1`, `sel_in`, `uop`, `branch_cond`), and presents the bundle on the next clock edge. It honours the execute stage's `global_disable` by squashing in-flight work into bubbles, and it detects illegal opcodes.

## Interface
- `SQUASH_CYCLES`, default 2: number of bubble cycles emitted after `global_disable` rises.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction word from fetch.
- `instr_valid` in 1: `instr` is valid this cycle.
- `instr_ready` out 1: decode accepts `instr` this cycle.
- `global_disable` in 1: from execute; branch taken, younger work must be discarded.
- `num_to_rhs` out 1, `num` out 32, `sel_p0` out 4, `sel_p1` out 4, `sel_in` out 4, `uop` out 5, `branch_cond` out 4: bundle to execute.
- `illegal_instr` out 1: an illegal opcode was decoded.

## Operation
- Encoding of `instr`:
  - [31:28] cond
  - [27:23] uop
  - [22] imm
  - [21:18] rd
  - [17:14] rn
  - [13:10] rm
  - [9:0] imm10
- Field mapping: `branch_cond`=cond, `uop`=uop, `num_to_rhs`=imm, `sel_in`=rd, `sel_p0`=rn, `sel_p1`=rm.
- `num` selection:
  - imm=0: `num`=0.
  - imm=1, cond≠4'b1111 (branch): sign-extended imm10.
  - imm=1, uop=MOV(8): zero-extended instr[17:0].
  - imm=1 otherwise: zero-extended imm10.
- Legal uops are 0–10. Uops 11–31 are illegal.
- State machine:
  - RUN: `instr_ready`=1. On `instr_valid`, the bundle register loads the decoded word. Without `instr_valid`, it loads a bubble.
  - SQUASH: entered from RUN when `global_disable`=1. `instr_ready`=1 and accepted words are dropped. The register loads a bubble. A down-counter starts at SQUASH_CYCLES−1; at 0 the FSM returns to RUN.
  - HALT: trap mode only (see Configuration). `instr_ready`=0, bubbles output forever, left only by reset.
- A bubble is `uop`=0, `branch_cond`=4'b1111, `num_to_rhs`=0, `num`=0, all selects 0.
- `global_disable` during SQUASH restarts the counter.
- `global_disable` together with an accepted word in RUN: the word is dropped and a bubble is loaded.
- Illegal word accepted in RUN: a bubble is loaded and `illegal_instr` pulses (non-trap mode).

## Timing
- Latency: word accepted at edge N appears on the bundle after edge N, and is consumed by execute at edge N+1.
- Throughput: one instruction per cycle in RUN.
- `instr_ready` is combinational from state only, never from `instr_valid`.
- Reset: async assert forces state RUN, counter 0, bundle = bubble, `illegal_instr`=0.
- Reset mid-SQUASH or mid-HALT returns to RUN immediately.
- `illegal_instr` is registered, aligned with the bubble it produced.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined: an illegal uop moves the FSM to HALT and `illegal_instr` stays high (sticky) until reset. A `global_disable` in the same cycle takes priority and goes to SQUASH.
- Undefined: an illegal uop becomes a bubble with a single-cycle `illegal_instr` pulse, the FSM stays in RUN, and HALT is unreachable.

## Structure
- Shared package `cpu_pkg`:
  - uop constants: NOP=0, ADD=1, SUB=2, AND=3, EOR=4, CMP=5, LSL=6, LSR=7, MOV=8, STR=9, LDR=10.
  - cond constants: AL=4'b1110, NONE=4'b1111.
  - Instruction field bit positions.
  - FSM state enum.
- One sub-module `instr_fields`: a purely combinational splitter producing the bundle plus a legal flag. `decode_stage` holds the FSM, the counter and the bundle register.

## Test plan
- Reset then `instr_valid`=0 → bundle is a bubble, `instr_ready`=1.
- MOV imm: cond=F, uop=8, imm=1, rd=1, instr[17:0]=0xCAFE → next cycle `uop`=8, `sel_in`=1, `num`=0x0000CAFE, `num_to_rhs`=1.
- Branch: cond=E, imm=1, imm10=0x3F6 → `branch_cond`=4'b1110, `num`=0xFFFFFFF6.
- ADD r4=r1+r2 streamed back to back with EOR; pulse `global_disable` on the EOR accept cycle → EOR dropped, 2 bubbles, then the next word decodes normally.
- Illegal uop 20:
  - Without `DECODE_ILLEGAL_TRAP_EN`: bubble plus a 1-cycle `illegal_instr` pulse, the next word is accepted.
  - With it defined: `instr_ready`=0 and `illegal_instr`=1 held until `rst_n` low.
- Assert `rst_n`=0 asynchronously mid-SQUASH → bundle is a bubble before the next edge, and RUN resumes after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: uop/cond constants, instruction field positions,
// the decode FSM state type and the execute control bundle.
package cpu_pkg;

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_SUB = 5'd2;
  localparam logic [4:0] UOP_AND = 5'd3;
  localparam logic [4:0] UOP_EOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_LSR = 5'd7;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_STR = 5'd9;
  localparam logic [4:0] UOP_LDR = 5'd10;

  localparam logic [3:0] COND_AL   = 4'b1110;
  localparam logic [3:0] COND_NONE = 4'b1111;

  localparam int unsigned COND_MSB  = 31;
  localparam int unsigned COND_LSB  = 28;
  localparam int unsigned UOP_MSB   = 27;
  localparam int unsigned UOP_LSB   = 23;
  localparam int unsigned IMM_BIT   = 22;
  localparam int unsigned RD_MSB    = 21;
  localparam int unsigned RD_LSB    = 18;
  localparam int unsigned RN_MSB    = 17;
  localparam int unsigned RN_LSB    = 14;
  localparam int unsigned RM_MSB    = 13;
  localparam int unsigned RM_LSB    = 10;
  localparam int unsigned IMM10_MSB = 9;
  localparam int unsigned MOVIMM_MSB = 17;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SQUASH,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic        num_to_rhs;
    logic [31:0] num;
    logic [3:0]  sel_p0;
    logic [3:0]  sel_p1;
    logic [3:0]  sel_in;
    logic [4:0]  uop;
    logic [3:0]  branch_cond;
  } bundle_t;

  localparam bundle_t BUBBLE = '{
    num_to_rhs:  1'b0,
    num:         32'h0,
    sel_p0:      4'h0,
    sel_p1:      4'h0,
    sel_in:      4'h0,
    uop:         UOP_NOP,
    branch_cond: COND_NONE
  };

endpackage

// File: rtl/decode_stage_instr_fields.sv
// Combinational splitter: instruction word -> execute bundle plus legal flag.
module instr_fields
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output bundle_t     bundle_o,
  output logic        legal_o
);

  logic [3:0]  cond;
  logic [4:0]  uop;
  logic        imm;
  logic [9:0]  imm10;
  logic [17:0] movimm;

  assign cond   = instr_i[COND_MSB:COND_LSB];
  assign uop    = instr_i[UOP_MSB:UOP_LSB];
  assign imm    = instr_i[IMM_BIT];
  assign imm10  = instr_i[IMM10_MSB:0];
  assign movimm = instr_i[MOVIMM_MSB:0];

  assign legal_o = (uop <= UOP_LDR);

  always_comb begin
    bundle_o             = BUBBLE;
    bundle_o.num_to_rhs  = imm;
    bundle_o.sel_p0      = instr_i[RN_MSB:RN_LSB];
    bundle_o.sel_p1      = instr_i[RM_MSB:RM_LSB];
    bundle_o.sel_in      = instr_i[RD_MSB:RD_LSB];
    bundle_o.uop         = uop;
    bundle_o.branch_cond = cond;
    // Branch offsets take precedence over the MOV wide immediate.
    if (!imm)                   bundle_o.num = '0;
    else if (cond != COND_NONE) bundle_o.num = {{22{imm10[9]}}, imm10};
    else if (uop == UOP_MOV)    bundle_o.num = {14'h0, movimm};
    else                        bundle_o.num = {22'h0, imm10};
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage feeding execute; squashes on global_disable.
// Optional macro DECODE_ILLEGAL_TRAP_EN: illegal uops halt the stage until reset.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        global_disable,
  output logic        num_to_rhs,
  output logic [31:0] num,
  output logic [3:0]  sel_p0,
  output logic [3:0]  sel_p1,
  output logic [3:0]  sel_in,
  output logic [4:0]  uop,
  output logic [3:0]  branch_cond,
  output logic        illegal_instr
);

  localparam int unsigned CW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SQUASH_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  bundle_t       bundle_q;
  logic          illegal_q;

  bundle_t       dec_bundle;
  logic          dec_legal;

  instr_fields u_fields (
    .instr_i  (instr),
    .bundle_o (dec_bundle),
    .legal_o  (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      bundle_q  <= BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          bundle_q  <= BUBBLE;
          illegal_q <= 1'b0;
          if (global_disable) begin
            state_q <= ST_SQUASH;
            cnt_q   <= CNT_INIT;
          end else if (instr_valid && dec_legal) begin
            bundle_q <= dec_bundle;
          end else if (instr_valid) begin
            illegal_q <= 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
            state_q   <= ST_HALT;
`endif
          end
        end
        ST_SQUASH: begin
          bundle_q  <= BUBBLE;
          illegal_q <= 1'b0;
          if (global_disable)   cnt_q   <= CNT_INIT;
          else if (cnt_q == '0) state_q <= ST_RUN;
          else                  cnt_q   <= cnt_q - 1'b1;
        end
        ST_HALT: begin
          bundle_q  <= BUBBLE;
          illegal_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_RUN;
          bundle_q  <= BUBBLE;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready   = (state_q != ST_HALT);
  assign num_to_rhs    = bundle_q.num_to_rhs;
  assign num           = bundle_q.num;
  assign sel_p0        = bundle_q.sel_p0;
  assign sel_p1        = bundle_q.sel_p1;
  assign sel_in        = bundle_q.sel_in;
  assign uop           = bundle_q.uop;
  assign branch_cond   = bundle_q.branch_cond;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (default and trap builds).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        global_disable = 1'b0;
  logic        num_to_rhs;
  logic [31:0] num;
  logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
  logic [4:0]  uop;
  logic        illegal_instr;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [53:0] BUB = {1'b0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd0, 4'hF};

  localparam logic [31:0] W_MOV   = 32'hF444CAFE;
  localparam logic [31:0] W_BR    = 32'hE04003F6;
  localparam logic [31:0] W_ADDI  = 32'hF0C003F6;
  localparam logic [31:0] W_ADD   = 32'hF0904800;
  localparam logic [31:0] W_EOR   = 32'hF2104800;
  localparam logic [31:0] W_SUB   = 32'hF10D5800;
  localparam logic [31:0] W_LDR   = 32'hF5000000;
  localparam logic [31:0] W_ILL20 = 32'hFA000000;
  localparam logic [31:0] W_ILL11 = 32'hF5800000;

  localparam logic [53:0] E_MOV  = {1'b1, 32'h0000CAFE, 4'h3, 4'h2, 4'h1, 5'd8, 4'hF};
  localparam logic [53:0] E_BR   = {1'b1, 32'hFFFFFFF6, 4'h0, 4'h0, 4'h0, 5'd0, 4'hE};
  localparam logic [53:0] E_ADDI = {1'b1, 32'h000003F6, 4'h0, 4'h0, 4'h0, 5'd1, 4'hF};
  localparam logic [53:0] E_ADD  = {1'b0, 32'h0, 4'h1, 4'h2, 4'h4, 5'd1, 4'hF};
  localparam logic [53:0] E_SUB  = {1'b0, 32'h0, 4'h5, 4'h6, 4'h3, 5'd2, 4'hF};
  localparam logic [53:0] E_LDR  = {1'b0, 32'h0, 4'h0, 4'h0, 4'h0, 5'd10, 4'hF};

  logic [53:0] bun;
  assign bun = {num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond};

  decode_stage #(.SQUASH_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .global_disable (global_disable),
    .num_to_rhs     (num_to_rhs),
    .num            (num),
    .sel_p0         (sel_p0),
    .sel_p1         (sel_p1),
    .sel_in         (sel_in),
    .uop            (uop),
    .branch_cond    (branch_cond),
    .illegal_instr  (illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bun !== BUB) begin
      n_errors++;
      $display("FAIL reset_bundle: got %h expected %h", bun, BUB);
    end
    n_checks++;
    if (instr_ready !== 1'b1 || illegal_instr !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got ready=%b illegal=%b expected ready=1 illegal=0",
               instr_ready, illegal_instr);
    end
  endtask

  task automatic test_immediates();
    logic [31:0] words [3] = '{W_MOV, W_BR, W_ADDI};
    logic [53:0] exps  [3] = '{E_MOV, E_BR, E_ADDI};
    for (int i = 0; i < 3; i++) begin
      instr = words[i];
      instr_valid = 1'b1;
      step();
      n_checks++;
      if (bun !== exps[i]) begin
        n_errors++;
        $display("FAIL imm_decode[%0d]: got %h expected %h", i, bun, exps[i]);
      end
    end
    instr_valid = 1'b0;
    step();
    n_checks++;
    if (bun !== BUB) begin
      n_errors++;
      $display("FAIL idle_bubble: got %h expected %h", bun, BUB);
    end
  endtask

  task automatic test_back_to_back();
    instr = W_ADD;
    instr_valid = 1'b1;
    step();
    n_checks++;
    if (bun !== E_ADD) begin
      n_errors++;
      $display("FAIL b2b_add: got %h expected %h", bun, E_ADD);
    end
    instr = W_EOR;
    global_disable = 1'b1;
    step();
    global_disable = 1'b0;
    instr = W_SUB;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bun !== BUB || instr_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL squash_bubble[%0d]: got %h ready=%b expected %h ready=1",
                 i, bun, instr_ready, BUB);
      end
      step();
    end
    n_checks++;
    if (bun !== E_SUB) begin
      n_errors++;
      $display("FAIL post_squash_sub: got %h expected %h", bun, E_SUB);
    end
    instr_valid = 1'b0;
    step();
  endtask

  task automatic test_squash_restart();
    instr = W_ADD;
    instr_valid = 1'b1;
    global_disable = 1'b1;
    step();
    step();
    global_disable = 1'b0;
    step();
    step();
    n_checks++;
    if (bun !== BUB) begin
      n_errors++;
      $display("FAIL restart_still_squash: got %h expected %h", bun, BUB);
    end
    step();
    n_checks++;
    if (bun !== E_ADD) begin
      n_errors++;
      $display("FAIL restart_resume: got %h expected %h", bun, E_ADD);
    end
    instr_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    instr = W_LDR;
    instr_valid = 1'b1;
    step();
    n_checks++;
    if (bun !== E_LDR || illegal_instr !== 1'b0) begin
      n_errors++;
      $display("FAIL ldr_legal: got %h ill=%b expected %h ill=0", bun, illegal_instr, E_LDR);
    end
    instr = W_ILL20;
    step();
    n_checks++;
    if (bun !== BUB || illegal_instr !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal20: got %h ill=%b expected %h ill=1", bun, illegal_instr, BUB);
    end
    instr = W_ADD;
    step();
`ifdef DECODE_ILLEGAL_TRAP_EN
    step();
    n_checks++;
    if (bun !== BUB || illegal_instr !== 1'b1 || instr_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_hold: got %h ill=%b ready=%b expected %h ill=1 ready=0",
               bun, illegal_instr, instr_ready, BUB);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (illegal_instr !== 1'b0 || instr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_reset: got ill=%b ready=%b expected ill=0 ready=1",
               illegal_instr, instr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (bun !== E_ADD) begin
      n_errors++;
      $display("FAIL after_halt_add: got %h expected %h", bun, E_ADD);
    end
`else
    n_checks++;
    if (bun !== E_ADD || illegal_instr !== 1'b0 || instr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_pulse_end: got %h ill=%b ready=%b expected %h ill=0 ready=1",
               bun, illegal_instr, instr_ready, E_ADD);
    end
    instr = W_ILL11;
    step();
    n_checks++;
    if (bun !== BUB || illegal_instr !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal11: got %h ill=%b expected %h ill=1", bun, illegal_instr, BUB);
    end
`endif
    instr_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    instr = W_MOV;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bun !== BUB) begin
      n_errors++;
      $display("FAIL async_reset_bundle: got %h expected %h", bun, BUB);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    global_disable = 1'b1;
    step();
    global_disable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    instr = W_SUB;
    instr_valid = 1'b1;
    step();
    n_checks++;
    if (bun !== E_SUB) begin
      n_errors++;
      $display("FAIL reset_mid_squash: got %h expected %h", bun, E_SUB);
    end
    instr_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_immediates();
    test_back_to_back();
    test_squash_restart();
    test_illegal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
